// File: rtl/brownout_sample_ctrl.sv
// brownout_sample_ctrl
//   Sequences ADC conversions while the BOD warning comparator is high.
//   Each new sample is compared with the previous one, and a falling step larger
//   than the programmable rate limit counts as a violation. DEBOUNCE consecutive
//   violations raise brownout. The critical comparator raises brownout
//   immediately. Brownout is then held for HOLD_CYCLES after the last trigger.
//
//   Optional feature macro: BOD_EVENT_CNT_EN adds event_cnt[7:0], a saturating
//   count of brownout rising edges.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   bod_warn        BOD warning comparator (level)
//   bod_crit        BOD critical comparator (level)
//   adc_start       one-cycle conversion request
//   adc_done        one-cycle conversion-complete strobe; adc_data is valid with it
//   adc_data        ADC sample
//   cfg_wr          rate-limit write strobe; cfg_rate_limit is the new value
//   brownout        registered brownout flag
//   adc_fault       sticky ADC timeout flag
//   event_cnt       brownout episode count (BOD_EVENT_CNT_EN only)
module brownout_sample_ctrl #(
  parameter int unsigned ADC_W          = 20,
  parameter int unsigned RATE_W         = 12,
  parameter int unsigned RATE_LIMIT_RST = 14,
  parameter int unsigned SAMPLE_DIV     = 16,
  parameter int unsigned ADC_TIMEOUT    = 32,
  parameter int unsigned DEBOUNCE       = 2,
  parameter int unsigned HOLD_CYCLES    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bod_warn,
  input  logic              bod_crit,
  output logic              adc_start,
  input  logic              adc_done,
  input  logic [ADC_W-1:0]  adc_data,
  input  logic              cfg_wr,
  input  logic [RATE_W-1:0] cfg_rate_limit,
  output logic              brownout,
  output logic              adc_fault
`ifdef BOD_EVENT_CNT_EN
  ,
  output logic [7:0]        event_cnt
`endif
);

  localparam int unsigned CNT_W  = $clog2(SAMPLE_DIV + 1);
  localparam int unsigned TO_W   = $clog2(ADC_TIMEOUT + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned VC_W   = $clog2(DEBOUNCE + 1);
  localparam int unsigned VC1_W  = VC_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_EVAL,
    S_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   div_cnt_q, div_cnt_d;
  logic [TO_W-1:0]    timer_q, timer_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [VC_W-1:0]    viol_cnt_q, viol_cnt_d;
  logic [ADC_W-1:0]   cur_q, cur_d;
  logic [ADC_W-1:0]   prev_q, prev_d;
  logic               prev_valid_q, prev_valid_d;
  logic [RATE_W-1:0]  limit_q, limit_d;
  logic               adc_start_q, adc_start_d;
  logic               brownout_q, brownout_d;
  logic               adc_fault_q, adc_fault_d;
`ifdef BOD_EVENT_CNT_EN
  logic [7:0]         event_cnt_q, event_cnt_d;
`endif

  logic [ADC_W-1:0]   diff;
  logic               viol;
  logic [VC_W-1:0]    viol_cnt_inc;
  logic               debounce_hit;

  // Slew evaluation on the captured sample; uses the limit register before any same-cycle write
  always_comb begin
    diff         = prev_q - cur_q;
    viol         = prev_valid_q && (prev_q > cur_q) && (diff > ADC_W'(limit_q));
    viol_cnt_inc = (viol_cnt_q == '1) ? viol_cnt_q : viol_cnt_q + VC_W'(1);
    debounce_hit = (VC1_W'(viol_cnt_q) + VC1_W'(1)) == VC1_W'(DEBOUNCE);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    timer_d      = timer_q;
    hold_d       = hold_q;
    viol_cnt_d   = viol_cnt_q;
    cur_d        = cur_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    brownout_d   = brownout_q;
    adc_fault_d  = adc_fault_q;
    limit_d      = cfg_wr ? cfg_rate_limit : limit_q;

    case (state_q)
      S_IDLE: begin
        if (!bod_warn) begin
          div_cnt_d    = '0;
          prev_valid_d = 1'b0;
          viol_cnt_d   = '0;
        end else if (div_cnt_q == CNT_W'(SAMPLE_DIV - 1)) begin
          div_cnt_d = '0;
          state_d   = S_START;
        end else begin
          div_cnt_d = div_cnt_q + CNT_W'(1);
        end
      end
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (adc_done) begin
          cur_d   = adc_data;
          state_d = S_EVAL;
        end else if (timer_q == TO_W'(ADC_TIMEOUT - 1)) begin
          adc_fault_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          timer_d = timer_q + TO_W'(1);
        end
      end
      S_EVAL: begin
        prev_d       = cur_q;
        prev_valid_d = 1'b1;
        state_d      = S_IDLE;
        if (viol) begin
          viol_cnt_d = viol_cnt_inc;
          if (debounce_hit) begin
            brownout_d = 1'b1;
            hold_d     = HOLD_W'(HOLD_CYCLES);
            state_d    = S_HOLD;
          end
        end else begin
          viol_cnt_d = '0;
        end
      end
      S_HOLD: begin
        if (hold_q == HOLD_W'(1)) begin
          brownout_d   = 1'b0;
          prev_valid_d = 1'b0;
          viol_cnt_d   = '0;
          state_d      = S_IDLE;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Critical comparator wins over everything, abandoning any conversion in flight
    if (bod_crit) begin
      state_d      = S_HOLD;
      brownout_d   = 1'b1;
      hold_d       = HOLD_W'(HOLD_CYCLES);
      div_cnt_d    = '0;
      timer_d      = timer_q;
      cur_d        = cur_q;
      prev_d       = prev_q;
      prev_valid_d = prev_valid_q;
      viol_cnt_d   = viol_cnt_q;
      adc_fault_d  = adc_fault_q;
    end

    adc_start_d = (state_d == S_START);
  end

`ifdef BOD_EVENT_CNT_EN
  // Count brownout rising edges; a reload while already in brownout is not a new event
  always_comb begin
    event_cnt_d = event_cnt_q;
    if (brownout_d && !brownout_q && (event_cnt_q != 8'hFF)) begin
      event_cnt_d = event_cnt_q + 8'd1;
    end
  end
`endif

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      div_cnt_q    <= '0;
      timer_q      <= '0;
      hold_q       <= '0;
      viol_cnt_q   <= '0;
      cur_q        <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      limit_q      <= RATE_W'(RATE_LIMIT_RST);
      adc_start_q  <= 1'b0;
      brownout_q   <= 1'b0;
      adc_fault_q  <= 1'b0;
`ifdef BOD_EVENT_CNT_EN
      event_cnt_q  <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      timer_q      <= timer_d;
      hold_q       <= hold_d;
      viol_cnt_q   <= viol_cnt_d;
      cur_q        <= cur_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      limit_q      <= limit_d;
      adc_start_q  <= adc_start_d;
      brownout_q   <= brownout_d;
      adc_fault_q  <= adc_fault_d;
`ifdef BOD_EVENT_CNT_EN
      event_cnt_q  <= event_cnt_d;
`endif
    end
  end

  assign adc_start = adc_start_q;
  assign brownout  = brownout_q;
  assign adc_fault = adc_fault_q;
`ifdef BOD_EVENT_CNT_EN
  assign event_cnt = event_cnt_q;
`endif

endmodule

// File: tb/tb_brownout_sample_ctrl.sv
// Testbench for brownout_sample_ctrl (default parameters).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_brownout_sample_ctrl;

  localparam int ADC_W       = 20;
  localparam int RATE_W      = 12;
  localparam int LIMIT_RST   = 14;
  localparam int SAMPLE_DIV  = 16;
  localparam int ADC_TIMEOUT = 32;
  localparam int DEBOUNCE    = 2;
  localparam int HOLD_CYCLES = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              bod_warn;
  logic              bod_crit;
  logic              adc_start;
  logic              adc_done;
  logic [ADC_W-1:0]  adc_data;
  logic              cfg_wr;
  logic [RATE_W-1:0] cfg_rate_limit;
  logic              brownout;
  logic              adc_fault;
`ifdef BOD_EVENT_CNT_EN
  logic [7:0]        event_cnt;
`endif

  int vectors = 0;
  int errors  = 0;

  // Reference model state: sample history, violation streak, active limit
  int m_limit;
  int m_prev;
  bit m_prev_valid;
  int m_streak;

  brownout_sample_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .bod_warn       (bod_warn),
    .bod_crit       (bod_crit),
    .adc_start      (adc_start),
    .adc_done       (adc_done),
    .adc_data       (adc_data),
    .cfg_wr         (cfg_wr),
    .cfg_rate_limit (cfg_rate_limit),
    .brownout       (brownout),
    .adc_fault      (adc_fault)
`ifdef BOD_EVENT_CNT_EN
    ,
    .event_cnt      (event_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_clear();
    m_prev_valid = 1'b0;
    m_streak     = 0;
  endtask

  // A sample violates when it falls from the previous one by more than the limit
  task automatic model_sample(input int cur, output bit bo);
    bit v;
    v = m_prev_valid && (m_prev > cur) && ((m_prev - cur) > m_limit);
    m_streak     = v ? m_streak + 1 : 0;
    m_prev       = cur;
    m_prev_valid = 1'b1;
    bo = (m_streak == DEBOUNCE);
    if (bo) model_clear();
  endtask

  task automatic do_reset();
    rst = 1'b1; bod_warn = 1'b0; bod_crit = 1'b0; adc_done = 1'b0;
    adc_data = '0; cfg_wr = 1'b0; cfg_rate_limit = '0;
    step(2);
    rst = 1'b0; bod_warn = 1'b1;
    m_limit = LIMIT_RST;
    model_clear();
  endtask

  task automatic wait_start(output int waits);
    waits = 0;
    while (adc_start !== 1'b1 && waits < 200) begin
      step(1);
      waits++;
    end
    if (adc_start !== 1'b1) begin
      vectors++; errors++;
      $display("FAIL adc_start_wait: no adc_start within %0d cycles", waits);
    end
  endtask

  // One conversion; returns one cycle after EVAL, optionally writing the limit during EVAL
  task automatic do_conv(input logic [ADC_W-1:0] sample, input int dly, input bit wr,
                         input logic [RATE_W-1:0] wr_val, output int waits);
    wait_start(waits);
    step(1 + dly);
    adc_done = 1'b1; adc_data = sample;
    step(1);
    adc_done = 1'b0; adc_data = ADC_W'($urandom);
    if (wr) begin cfg_wr = 1'b1; cfg_rate_limit = wr_val; end
    step(1);
    cfg_wr = 1'b0;
  endtask

  task automatic check_hold(input string name);
    step(HOLD_CYCLES - 1);
    vectors++;
    if (brownout !== 1'b1) begin
      errors++; $display("FAIL %s hold_end: brownout got %b want 1", name, brownout);
    end
    step(1);
    vectors++;
    if (brownout !== 1'b0) begin
      errors++; $display("FAIL %s release: brownout got %b want 0", name, brownout);
    end
  endtask

  task automatic conv_and_check(input string name, input int sample, input int dly,
                                input bit wr, input int wr_val, input bit chk_waits);
    int waits;
    bit exp_bo;
    model_sample(sample, exp_bo);
    do_conv(ADC_W'(sample), dly, wr, RATE_W'(wr_val), waits);
    if (wr) m_limit = wr_val;
    if (chk_waits) begin
      vectors++;
      if (waits != SAMPLE_DIV) begin
        errors++; $display("FAIL %s interval: got %0d want %0d", name, waits, SAMPLE_DIV);
      end
    end
    vectors++;
    if (brownout !== exp_bo) begin
      errors++; $display("FAIL %s sample %0d: brownout got %b want %b", name, sample, brownout, exp_bo);
    end
    if (exp_bo && brownout === 1'b1) check_hold(name);
  endtask

  // Drop bod_warn for one IDLE cycle so the sample history is forgotten
  task automatic clear_history();
    bod_warn = 1'b0;
    step(1);
    bod_warn = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    rst = 1'b1; bod_warn = 1'b1; bod_crit = 1'b0; adc_done = 1'b0;
    adc_data = '0; cfg_wr = 1'b0; cfg_rate_limit = '0;
    step(3);
    vectors += 3;
    if (brownout !== 1'b0)  begin errors++; $display("FAIL reset brownout: got %b want 0", brownout); end
    if (adc_start !== 1'b0) begin errors++; $display("FAIL reset adc_start: got %b want 0", adc_start); end
    if (adc_fault !== 1'b0) begin errors++; $display("FAIL reset adc_fault: got %b want 0", adc_fault); end
    do_reset();
  endtask

  task automatic test_slew();
    conv_and_check("slew", 1000, 2, 1'b0, 0, 1'b1);
    conv_and_check("slew", 990,  0, 1'b0, 0, 1'b1);
    conv_and_check("slew", 975,  5, 1'b0, 0, 1'b1);
    conv_and_check("slew", 960,  1, 1'b0, 0, 1'b1);
  endtask

  task automatic test_equal_limit();
    clear_history();
    conv_and_check("eq_limit", 1000, 1, 1'b0, 0, 1'b1);
    conv_and_check("eq_limit", 986,  1, 1'b0, 0, 1'b1);
    conv_and_check("eq_limit", 972,  1, 1'b0, 0, 1'b1);
    conv_and_check("eq_limit", 980,  1, 1'b0, 0, 1'b1);
    conv_and_check("eq_limit", 965,  1, 1'b0, 0, 1'b1);
    conv_and_check("eq_limit", 966,  1, 1'b0, 0, 1'b1);
    conv_and_check("eq_limit", 951,  1, 1'b0, 0, 1'b1);
  endtask

  task automatic test_crit_wait();
    int waits;
    int starts;
    wait_start(waits);
    step(1);
    bod_crit = 1'b1;
    step(1);
    bod_crit = 1'b0;
    vectors++;
    if (brownout !== 1'b1) begin errors++; $display("FAIL crit_rise: brownout got %b want 1", brownout); end
    step(2);
    adc_done = 1'b1; adc_data = ADC_W'(0);
    step(1);
    adc_done = 1'b0;
    starts = 0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (adc_start === 1'b1) starts++;
    end
    vectors += 3;
    if (brownout !== 1'b1) begin errors++; $display("FAIL crit_hold: brownout got %b want 1", brownout); end
    if (starts != 0) begin errors++; $display("FAIL crit_no_start: got %0d starts want 0", starts); end
    step(1);
    if (brownout !== 1'b0) begin errors++; $display("FAIL crit_release: brownout got %b want 0", brownout); end
    model_clear();
    wait_start(waits);
    vectors++;
    if (waits != SAMPLE_DIV) begin errors++; $display("FAIL crit_interval: got %0d want %0d", waits, SAMPLE_DIV); end
  endtask

  task automatic test_timeout();
    int waits;
    wait_start(waits);
    step(ADC_TIMEOUT);
    vectors++;
    if (adc_fault !== 1'b0) begin errors++; $display("FAIL timeout_early: adc_fault got %b want 0", adc_fault); end
    step(1);
    vectors += 2;
    if (adc_fault !== 1'b1) begin errors++; $display("FAIL timeout_flag: adc_fault got %b want 1", adc_fault); end
    if (brownout !== 1'b0)  begin errors++; $display("FAIL timeout_bo: brownout got %b want 0", brownout); end
    wait_start(waits);
    vectors++;
    if (waits != SAMPLE_DIV) begin errors++; $display("FAIL timeout_interval: got %0d want %0d", waits, SAMPLE_DIV); end
    step(5);
    vectors++;
    if (adc_fault !== 1'b1) begin errors++; $display("FAIL timeout_sticky: adc_fault got %b want 1", adc_fault); end
  endtask

  task automatic test_cfg_and_rst();
    do_reset();
    vectors++;
    if (adc_fault !== 1'b0) begin errors++; $display("FAIL rst_clears_fault: adc_fault got %b want 0", adc_fault); end
    cfg_wr = 1'b1; cfg_rate_limit = RATE_W'(5);
    step(1);
    cfg_wr = 1'b0;
    m_limit = 5;
    conv_and_check("cfg5", 100, 0, 1'b0, 0, 1'b0);
    conv_and_check("cfg5", 94,  3, 1'b0, 0, 1'b1);
    // Final sample raises brownout; stop inside HOLD and reset asynchronously
    begin
      int waits;
      bit exp_bo;
      model_sample(88, exp_bo);
      do_conv(ADC_W'(88), 2, 1'b0, '0, waits);
      vectors++;
      if (brownout !== exp_bo) begin errors++; $display("FAIL cfg5 raise: brownout got %b want %b", brownout, exp_bo); end
    end
    step(10);
    rst = 1'b1;
    #1;
    vectors++;
    if (brownout !== 1'b0) begin errors++; $display("FAIL async_rst: brownout got %b want 0", brownout); end
    @(negedge clk);
    rst = 1'b0;
    m_limit = LIMIT_RST;
    model_clear();
    conv_and_check("lim_rst", 200, 1, 1'b0, 0, 1'b1);
    conv_and_check("lim_rst", 190, 1, 1'b0, 0, 1'b1);
    conv_and_check("lim_rst", 180, 1, 1'b0, 0, 1'b1);
    conv_and_check("lim_rst", 165, 1, 1'b0, 0, 1'b1);
    conv_and_check("lim_rst", 150, 1, 1'b0, 0, 1'b1);
  endtask

  task automatic test_random();
    int last;
    int s;
    int r;
    int d;
    bit wr;
    do_reset();
    last = 500000;
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7) begin
        d = int'($urandom_range(0, 25));
        s = (last > d) ? last - d : 0;
      end else if (r == 7) begin
        s = last + int'($urandom_range(0, 20));
        if (s > 1048575) s = 1048575;
      end else begin
        s = int'($urandom_range(0, 1048575));
      end
      last = s;
      wr = ($urandom_range(0, 4) == 0);
      conv_and_check("random", s, int'($urandom_range(0, 8)), wr, int'($urandom_range(0, 30)), 1'b1);
      if ($urandom_range(0, 5) == 0) clear_history();
    end
    vectors++;
    if (adc_fault !== 1'b0) begin errors++; $display("FAIL random_fault: adc_fault got %b want 0", adc_fault); end
  endtask

`ifdef BOD_EVENT_CNT_EN
  task automatic test_event_cnt();
    do_reset();
    vectors++;
    if (event_cnt !== 8'd0) begin errors++; $display("FAIL evt_reset: got %0d want 0", event_cnt); end
    bod_crit = 1'b1; step(1); bod_crit = 1'b0;
    step(HOLD_CYCLES);
    bod_crit = 1'b1; step(1); bod_crit = 1'b0;
    step(10);
    bod_crit = 1'b1; step(1); bod_crit = 1'b0;
    vectors++;
    if (event_cnt !== 8'd2) begin errors++; $display("FAIL evt_reload: got %0d want 2", event_cnt); end
    step(HOLD_CYCLES);
    bod_crit = 1'b1; step(1); bod_crit = 1'b0;
    step(HOLD_CYCLES);
    vectors += 2;
    if (event_cnt !== 8'd3) begin errors++; $display("FAIL evt_count: got %0d want 3", event_cnt); end
    if (brownout !== 1'b0)  begin errors++; $display("FAIL evt_release: brownout got %b want 0", brownout); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_slew();
    test_equal_limit();
    test_crit_wait();
    test_timeout();
    test_cfg_and_rst();
    test_random();
`ifdef BOD_EVENT_CNT_EN
    test_event_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
